// File: rtl/punc_pkg.sv
// Shared definitions for the PUnC instruction-fetch front end.
package punc_pkg;
  localparam int unsigned ADDR_W_DEF   = 16;
  localparam int unsigned DATA_W_DEF   = 16;
  localparam logic [15:0] RESET_PC_DEF = 16'h0000;
  localparam int unsigned PC_INC       = 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_DRAIN  = 2'd2,
    S_HALTED = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/punc_ifetch_fifo.sv
// Prefetch FIFO: DEPTH registered entries with push/pop/flush; head is the
// registered entry at the read pointer.
module punc_ifetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     valid,
  output logic [WIDTH-1:0]         head
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             pop_ok;

  assign valid  = (count != '0);
  assign pop_ok = pop && valid;
  assign head   = mem[rd_ptr];

  // Flush has priority over any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
    !(push && !flush && count == DEPTH_C));
endmodule

// File: rtl/punc_fetch_unit.sv
// PUnC LC3 fetch front end: owns the fetch PC, runs one-outstanding imem
// requests and feeds fetched words plus PC+1 to control through a FIFO.
module punc_fetch_unit
  import punc_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEF,
  parameter int unsigned       DATA_W   = DATA_W_DEF,
  parameter int unsigned       DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic                   imem_ack,
  input  logic [DATA_W-1:0]      imem_rdata,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_pc,
  input  logic                   halt,
  output logic                   ir_valid,
  output logic [DATA_W-1:0]      ir_data,
  output logic [ADDR_W-1:0]      ir_pc,
  input  logic                   ir_ready,
  output logic [$clog2(DEPTH):0] buf_count,
  output logic                   halted
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);

  fetch_state_e state, state_nxt;
  logic [ADDR_W-1:0]        fetch_pc, req_addr, push_pc;
  logic                     halt_q, halt_eff, issue, push, pop;
  logic [DATA_W+ADDR_W-1:0] head;

  assign halt_eff = halt | halt_q;
  // Space is judged on the registered count; a same-cycle pop frees nothing yet.
  assign issue    = (state == S_IDLE) && !halt_eff && !redirect_valid && (buf_count < DEPTH_C);
  assign push     = (state == S_REQ) && imem_ack && !redirect_valid;
  assign pop      = ir_valid && ir_ready;
  assign push_pc  = req_addr + PC_STEP;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (halt_eff)   state_nxt = S_HALTED;
        else if (issue) state_nxt = S_REQ;
      end
      S_REQ: begin
        if (imem_ack)            state_nxt = halt_eff ? S_HALTED : S_IDLE;
        else if (redirect_valid) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (imem_ack) state_nxt = halt_eff ? S_HALTED : S_IDLE;
      end
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // req_addr keeps the issued address so DRAIN can hold it after fetch_pc moves.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      halt_q   <= 1'b0;
    end else begin
      halt_q <= halt_q | halt;
      if (issue) req_addr <= fetch_pc;
      if (redirect_valid) fetch_pc <= redirect_pc;
      else if (push)      fetch_pc <= push_pc;
    end
  end

  always_comb begin
    imem_req  = rst && (issue || state == S_REQ || state == S_DRAIN);
    imem_addr = (state == S_IDLE) ? fetch_pc : req_addr;
    halted    = (state == S_HALTED);
  end

  punc_ifetch_fifo #(
    .WIDTH(DATA_W + ADDR_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({imem_rdata, push_pc}),
    .pop   (pop),
    .flush (redirect_valid),
    .count (buf_count),
    .valid (ir_valid),
    .head  (head)
  );

  assign {ir_data, ir_pc} = head;
endmodule

// File: doc/punc_fetch_unit.md
Name: punc_fetch_unit

Overview:
- Instruction-fetch front end for the PUnC LC3 processor.
- Owns the fetch PC and issues reads to instruction memory over a variable-latency req/ack handshake.
- Buffers fetched words in a small prefetch FIFO and presents them, with their incremented PC, to the control unit through a valid/ready handshake.
- Accepts redirects (BR taken, JMP, JSR) from the control unit, flushing the FIFO and discarding any wrong-path response still in flight.

Parameters:
- ADDR_W, 16, width of instruction address and PC.
- DATA_W, 16, width of an instruction word.
- DEPTH, 2, prefetch FIFO entries (power of two, ≥2).
- RESET_PC, 16'h0000, fetch PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  ADDR_W  read address; held stable while imem_req=1.
- imem_ack  in  1  one-cycle pulse; imem_rdata is valid in the same cycle.
- imem_rdata  in  DATA_W  returned instruction word.
- redirect_valid  in  1  one-cycle pulse: load a new fetch PC.
- redirect_pc  in  ADDR_W  redirect target.
- halt  in  1  HLT decoded; sticky stop of new fetches.
- ir_valid  out  1  head FIFO entry is available.
- ir_data  out  DATA_W  head instruction word.
- ir_pc  out  ADDR_W  address of the head instruction + 1 (LC3 PC-relative base).
- ir_ready  in  1  control consumes the head entry when ir_valid & ir_ready.
- buf_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- halted  out  1  halt accepted and no request outstanding.

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_PC, FIFO empty, state=IDLE.
  - imem_req=0, ir_valid=0, buf_count=0, halted=0.
- FSM states: IDLE, REQ, DRAIN, HALTED.
- IDLE:
  - If !halt and buf_count+(pop this cycle?0:0) < DEPTH, assert imem_req, imem_addr=fetch_pc, and go to REQ.
  - The space check is registered-count based; a same-cycle pop does not create space until the next cycle.
- REQ:
  - imem_req held at 1 and imem_addr stable until imem_ack.
  - On ack: push {imem_rdata, fetch_pc+1}, fetch_pc <= fetch_pc+1.
  - Next state after ack: IDLE, or HALTED if halt is latched.
  - Back-to-back fetch is allowed: a new request may be issued in the cycle after ack.
- Outstanding requests: at most 1. A request is only issued if the FIFO can accept its response.
- Redirect:
  - Flushes the FIFO in that cycle (buf_count=0 and ir_valid=0 next cycle) and sets fetch_pc <= redirect_pc.
  - If redirect arrives in REQ without ack, go to DRAIN.
  - If it coincides with ack, drop that response and go to IDLE.
  - From IDLE, the first request to redirect_pc is issued on the next cycle.
- DRAIN:
  - imem_req stays 1 at the old address until ack, because the memory has already accepted it.
  - The response is discarded; then go to IDLE.
  - A second redirect in DRAIN only updates fetch_pc.
- Simultaneous pop and redirect: the redirect wins and the whole FIFO is flushed; the pop is still considered consumed by control.
- Simultaneous push and pop with FIFO full: only legal when an outstanding request exists, which the space rule prevents; the implementation asserts this never occurs.
- Address arithmetic: fetch_pc+1 wraps modulo 2^ADDR_W (16'hFFFF → 16'h0000).
- Halt:
  - Latched on assertion.
  - No new requests are issued; an in-flight request completes and is pushed.
  - The FIFO continues to drain to control.
  - halted=1 once no request is outstanding; only reset clears it.
- A redirect while halted updates fetch_pc but issues nothing.
- imem_ack when no request is outstanding is ignored.
- Outputs ir_data and ir_pc are the registered FIFO head and are don't-care when ir_valid=0.
- Latency: redirect to first imem_req = 1 cycle; ack to ir_valid = 1 cycle.

Decomposition:
- Shared package (punc_pkg): ADDR_W/DATA_W defaults, RESET_PC, fetch FSM state encodings, and the PC-increment constant.
- One natural sub-module: punc_ifetch_fifo, a synchronous DEPTH-entry FIFO with push/pop/flush, count, and head outputs. The FSM, PC, and handshake logic stay in the top.

Test Plan:
- Reset then 1-cycle-latency memory returning mem[a]=16'h1000+a, ir_ready=1 → imem_addr sequence 0,1,2,…; ir_data 16'h1000,16'h1001,…; ir_pc 1,2,…
- ir_ready=0 for 10 cycles → exactly DEPTH=2 words buffered, imem_req=0, buf_count=2; releasing ir_ready delivers them in order with no loss.
- Memory latency 4 cycles; redirect_pc=16'h3000 pulsed 1 cycle after req at addr 5 → req held at 5 until ack, that word is dropped (never ir_valid), next request addr=16'h3000.
- Redirect coinciding with ack and with an ir_ready pop → FIFO empty next cycle, next imem_addr=redirect_pc.
- fetch_pc=16'hFFFF → after ack, ir_pc=16'h0000 and next imem_addr=16'h0000.
- halt asserted during in-flight request at addr 7 → word 7 delivered, no further imem_req, halted=1; rst low mid-REQ → all outputs zero immediately, fetch restarts at RESET_PC after release.
